decodificador_teclado: RTL and testbench

DECODIFICADOR_TECLADO -- requirements
Module: decodificador_teclado

---
 rtl/decodificador_teclado.sv | 106 ++++++++++
 tb/tb_decodificador_teclado.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/decodificador_teclado.sv
// decodificador_teclado: debounced 4x4 keypad decoder driven by an external one-hot column scan.
// Define KEYPAD_SYNC_EN to pass filas/columnas through 2-flop synchronizers (adds 2 cycles latency).
module decodificador_teclado #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] columnas,
    input  logic [3:0] filas,
    output logic [3:0] tecla,
    output logic       tecla_valida,
    output logic       tecla_presionada
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;
    localparam logic [7:0] LIM = 8'(DEBOUNCE_SCANS);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d, rel_q, rel_d;
    logic [1:0] col_q, col_d, row_q, row_d;
    logic [3:0] tecla_d;
    logic valida_d, pres_d;
    logic [3:0] col_smp, fil_smp;
`ifdef KEYPAD_SYNC_EN
    logic [3:0] col_s1, fil_s1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1  <= '0;
            fil_s1  <= '0;
            col_smp <= '0;
            fil_smp <= '0;
        end else begin
            col_s1  <= columnas;
            fil_s1  <= filas;
            col_smp <= col_s1;
            fil_smp <= fil_s1;
        end
    end
`else
    assign col_smp = columnas;
    assign fil_smp = filas;
`endif
    logic valid, hit, row_on;
    logic [1:0] col_idx, row_idx;
    assign valid   = (col_smp != 4'd0) && ((col_smp & (col_smp - 4'd1)) == 4'd0);
    assign col_idx = col_smp[0] ? 2'd0 : col_smp[1] ? 2'd1 : col_smp[2] ? 2'd2 : 2'd3;
    assign row_idx = fil_smp[0] ? 2'd0 : fil_smp[1] ? 2'd1 : fil_smp[2] ? 2'd2 : 2'd3;
    assign hit     = valid && col_smp[col_q];
    assign row_on  = fil_smp[row_q];
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rel_d    = rel_q;
        col_d    = col_q;
        row_d    = row_q;
        tecla_d  = tecla;
        valida_d = 1'b0;
        pres_d   = tecla_presionada;
        case (state_q)
            IDLE: if (valid && fil_smp != 4'd0) begin
                col_d   = col_idx;
                row_d   = row_idx;
                cnt_d   = 8'd1;
                state_d = DEBOUNCE;
            end
            DEBOUNCE: if (cnt_q >= LIM) begin
                state_d  = PRESSED;
                tecla_d  = {row_q, col_q};
                valida_d = 1'b1;
                pres_d   = 1'b1;
                cnt_d    = 8'd0;
                rel_d    = 8'd0;
            end else if (hit) begin
                cnt_d   = !row_on ? 8'd0 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                state_d = row_on ? DEBOUNCE : IDLE;
            end
            PRESSED: if (rel_q >= LIM) begin
                state_d = IDLE;
                pres_d  = 1'b0;
                rel_d   = 8'd0;
            end else if (hit) begin
                rel_d = row_on ? 8'd0 : (rel_q == 8'hFF) ? rel_q : rel_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            rel_q            <= '0;
            col_q            <= '0;
            row_q            <= '0;
            tecla            <= '0;
            tecla_valida     <= 1'b0;
            tecla_presionada <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            rel_q            <= rel_d;
            col_q            <= col_d;
            row_q            <= row_d;
            tecla            <= tecla_d;
            tecla_valida     <= valida_d;
            tecla_presionada <= pres_d;
        end
    end
endmodule

// File: tb/tb_decodificador_teclado.sv
// tb_decodificador_teclado: randomized rotating-scan stimulus checked against a behavioural keypad model.
module tb_decodificador_teclado;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] columnas = '0, filas = '0;
    logic [3:0] tecla;
    logic tecla_valida, tecla_presionada;
    int tests = 0, fails = 0, pulses = 0, r = 0;
    int m_phase, m_key, m_cnt, m_rel, m_tecla, m_val, m_pres;

    always #5 clk = ~clk;

    decodificador_teclado #(.DEBOUNCE_SCANS(N)) dut (
        .clk(clk), .rst_n(rst_n), .columnas(columnas), .filas(filas),
        .tecla(tecla), .tecla_valida(tecla_valida), .tecla_presionada(tecla_presionada)
    );

    task automatic check(string tag, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_key = 0; m_cnt = 0; m_rel = 0; m_tecla = 0; m_val = 0; m_pres = 0;
    endtask

    // phase: 0 waiting for a key, 1 confirming candidate m_key, 2 key accepted
    task automatic model_step(logic [3:0] c, logic [3:0] f);
        int ci, lo;
        m_val = 0;
        if (m_phase == 1 && m_cnt >= N) begin
            m_phase = 2; m_tecla = m_key; m_val = 1; m_pres = 1; m_cnt = 0; m_rel = 0;
        end else if (m_phase == 2 && m_rel >= N) begin
            m_phase = 0; m_pres = 0; m_rel = 0;
        end else if ($countones(c) == 1) begin
            ci = $clog2(c);
            lo = 0;
            for (int i = 3; i >= 0; i--) if (f[i]) lo = i;
            if (m_phase == 0 && f != 0) begin
                m_key = lo * 4 + ci; m_cnt = 1; m_phase = 1;
            end else if (m_phase == 1 && ci == m_key % 4) begin
                if (f[m_key / 4]) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                else begin m_phase = 0; m_cnt = 0; end
            end else if (m_phase == 2 && ci == m_key % 4) begin
                m_rel = f[m_key / 4] ? 0 : ((m_rel < 255) ? m_rel + 1 : 255);
            end
        end
    endtask

    function automatic logic [3:0] rows_of(logic [15:0] keys, int c);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = keys[i * 4 + c];
        return v;
    endfunction

    task automatic step(logic [3:0] c, logic [3:0] f);
        columnas = c;
        filas = f;
        @(posedge clk);
        if (rst_n) model_step(c, f);
        #1;
        check("tecla", int'(tecla), m_tecla);
        check("tecla_valida", int'(tecla_valida), m_val);
        check("tecla_presionada", int'(tecla_presionada), m_pres);
        if (tecla_valida) pulses++;
    endtask

    task automatic run(logic [15:0] keys, int n, int bad_pct);
        logic [3:0] bad;
        for (int k = 0; k < n; k++) begin
            if (bad_pct > 0 && $urandom_range(99) < bad_pct) begin
                bad = 4'($urandom_range(15));
                if ($countones(bad) == 1) bad = 4'b0011;
                step(bad, rows_of(keys, r));
            end else begin
                step(4'(1 << r), rows_of(keys, r));
                r = (r + 1) % 4;
            end
        end
    endtask

    initial begin
        logic [15:0] keys;
        model_reset();
        rst_n = 1'b0;
        repeat (3) step(4'b0001, 4'b1111);
        rst_n = 1'b1;
        r = 0;
        // accept key 9 (row 2, column 1)
        pulses = 0;
        run(16'h1 << 9, 24, 0);
        check("acc_pulses", pulses, 1);
        check("acc_code", int'(tecla), 9);
        check("acc_held", int'(tecla_presionada), 1);
        // bouncing release: 3 clear scans, 1 pressed, then 4 clear
        pulses = 0;
        run(16'h0, 12, 0);
        run(16'h1 << 9, 4, 0);
        run(16'h0, 12, 0);
        check("rel_still_held", int'(tecla_presionada), 1);
        run(16'h0, 8, 0);
        check("rel_pulses", pulses, 0);
        check("rel_done", int'(tecla_presionada), 0);
        // aborted debounce leaves tecla untouched
        pulses = 0;
        run(16'h1 << 6, 8, 0);
        run(16'h0, 12, 0);
        check("abort_pulses", pulses, 0);
        check("abort_code", int'(tecla), 9);
        // keys 0 and 15 together, scan aligned to column 0
        run(16'h0, (4 - r) % 4, 0);
        pulses = 0;
        run(16'h8001, 24, 0);
        run(16'h0, 24, 0);
        check("multi_pulses", pulses, 1);
        check("multi_code", int'(tecla), 0);
        // reset during the third debounce scan of key 9
        run(16'h0, (4 - r) % 4, 0);
        pulses = 0;
        run(16'h1 << 9, 9, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", int'(tecla_valida), 0);
        check("rst_pres", int'(tecla_presionada), 0);
        run(16'h1 << 9, 3, 0);
        check("rst_pulses", pulses, 0);
        rst_n = 1'b1;
        run(16'h1 << 9, 24, 0);
        check("rst_resume_pulses", pulses, 1);
        check("rst_resume_code", int'(tecla), 9);
        run(16'h0, 24, 0);
        // invalid column patterns interleaved
        pulses = 0;
        run(16'h1 << 5, 60, 30);
        check("bad_col_code", int'(tecla), 5);
        run(16'h0, 60, 30);
        check("bad_col_pulses", pulses, 1);
        check("bad_col_rel", int'(tecla_presionada), 0);
        // random key activity
        for (int b = 0; b < 40; b++) begin
            case ($urandom_range(3))
                0: keys = 16'h0;
                1, 2: keys = 16'h1 << $urandom_range(15);
                default: keys = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
            endcase
            run(keys, $urandom_range(4, 40), 10);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
